// File: rtl/dmx_output_module.sv
// DMX512 transmit stage: replays a captured frame as Break, MAB and 8N2 slots.
// Ports: clk/rst, start + n_slots launch, rd_en/rd_addr/rd_data buffer port,
//        tx line, de driver enable, busy while sending, done pulse at frame end.
module dmx_output_module #(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int BAUD_RATE = 250_000,
    parameter int BREAK_US  = 176,
    parameter int MAB_US    = 12,
    parameter int MAX_SLOTS = 513
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] n_slots,
    output logic       rd_en,
    output logic [9:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       de,
    output logic       busy,
    output logic       done
);

    localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
    localparam int BREAK_CLKS = CLK_FREQ / 1_000_000 * BREAK_US;
    localparam int MAB_CLKS   = CLK_FREQ / 1_000_000 * MAB_US;
    localparam int CW_RAW     = $clog2(BREAK_CLKS + 1);
    localparam int CW         = (CW_RAW < 16) ? 16 : CW_RAW;

    localparam logic [CW-1:0] BREAK_LAST = CW'(BREAK_CLKS - 1);
    localparam logic [CW-1:0] MAB_LAST   = CW'(MAB_CLKS - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CLKS - 1);
    localparam logic [9:0]    MAX_CNT    = 10'(MAX_SLOTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BREAK = 2'd1;
    localparam logic [1:0] S_MAB   = 2'd2;
    localparam logic [1:0] S_SLOT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    slot_q, slot_d;
    logic [9:0]    count_q, count_d;
    logic [7:0]    next_q, next_d;
    logic [7:0]    shift_q, shift_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;

    logic [9:0] slot_nx;
    assign slot_nx = slot_q + 10'd1;

    // Prefetch of the following slot happens on the first start-bit cycle.
    assign rd_en = ((state_q == S_MAB) && (cnt_q == '0))
                || ((state_q == S_SLOT) && (bit_q == 4'd0)
                    && (cnt_q == '0) && (slot_nx < count_q));
    assign rd_addr = (state_q == S_SLOT) ? slot_nx : 10'd0;

    assign busy = (state_q != S_IDLE);
    assign de   = busy;
    assign done = done_q;

    // Data bits leave from shift_q[0]; the register refills with ones,
    // so the two stop bits come out of the same path.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_BREAK: tx = 1'b0;
            S_SLOT:  tx = (bit_q == 4'd0) ? 1'b0 : shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        count_d = count_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        pend_d  = rd_en;
        // rd_data is valid the cycle after the strobe
        next_d  = pend_q ? rd_data : next_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BREAK;
                    cnt_d   = '0;
                    if (n_slots == 10'd0)
                        count_d = 10'd1;
                    else if (n_slots > MAX_CNT)
                        count_d = MAX_CNT;
                    else
                        count_d = n_slots;
                end
            end
            S_BREAK: begin
                if (cnt_q == BREAK_LAST) begin
                    state_d = S_MAB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MAB: begin
                if (cnt_q == MAB_LAST) begin
                    state_d = S_SLOT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    slot_d  = 10'd0;
                    shift_d = next_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SLOT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd10) begin
                        if (slot_nx == count_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            slot_d  = slot_nx;
                            bit_d   = 4'd0;
                            shift_d = next_d;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q != 4'd0)
                            shift_d = {1'b1, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            slot_q  <= 10'd0;
            count_q <= 10'd0;
            next_q  <= 8'd0;
            shift_q <= 8'd0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            next_q  <= next_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dmx_output_module.sv
// Self-checking bench for dmx_output_module with scaled timing parameters.
// Frames are compared cycle by cycle against a line-level model of DMX512.
module tb_dmx_output_module;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 500_000;
    localparam int BRK_US   = 176;
    localparam int MAB_US   = 12;
    localparam int MAXS     = 513;

    localparam int BIT = CLK_FREQ / BAUD;
    localparam int BRK = CLK_FREQ / 1_000_000 * BRK_US;
    localparam int MAB = CLK_FREQ / 1_000_000 * MAB_US;

    typedef struct {
        int n_req;
        int exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] n_slots;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       de;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:1023];
    int tests = 0;
    int fails = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    // Frame buffer: registered read, data one cycle after the strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    dmx_output_module #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD),
        .BREAK_US (BRK_US),
        .MAB_US   (MAB_US),
        .MAX_SLOTS(MAXS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_slots(n_slots),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .de     (de),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string name, input bit ok,
                         input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected line level t cycles after the start pulse (t >= 1)
    function automatic bit exp_tx(input int t);
        int u, s, b;
        logic [7:0] byt;
        if (t <= BRK) return 1'b0;
        if (t <= BRK + MAB) return 1'b1;
        u = t - BRK - MAB - 1;
        s = u / (11 * BIT);
        b = (u % (11 * BIT)) / BIT;
        byt = mem[s];
        if (b == 0) return 1'b0;
        if (b <= 8) return byt[b-1];
        return 1'b1;
    endfunction

    task automatic run_frame(input int n_req, input int exp_cnt,
                             input bit chained, input int poke_t,
                             input int chain_n, input string tag);
        int L;
        int bad_tx = -1;
        int bad_ctl = -1;
        int bad_rd = -1;
        int nreads = 0;
        logic [9:0] a;
        L = BRK + MAB + exp_cnt * 11 * BIT;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
            n_slots = n_req[9:0];
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 1; t <= L; t++) begin
            if (tx !== exp_tx(t) && bad_tx < 0) bad_tx = t;
            if ((de !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
                && bad_ctl < 0) bad_ctl = t;
            if (rd_en) begin
                a = nreads[9:0];
                if (rd_addr !== a && bad_rd < 0) bad_rd = nreads;
                nreads++;
            end
            start = (t == poke_t);
            if (t == poke_t) n_slots = 10'd1;
            @(negedge clk);
        end
        check({tag, "_tx_first_bad_cycle"}, bad_tx < 0, bad_tx, -1);
        check({tag, "_ctl_first_bad_cycle"}, bad_ctl < 0, bad_ctl, -1);
        check({tag, "_read_count"}, nreads == exp_cnt, nreads, exp_cnt);
        check({tag, "_read_order_bad_idx"}, bad_rd < 0, bad_rd, -1);
        check({tag, "_done_cycle_dbdtr"},
              {done, busy, de, tx, rd_en} == 5'b10010,
              int'({done, busy, de, tx, rd_en}), 18);
        if (chain_n > 0) begin
            start = 1'b1;
            n_slots = chain_n[9:0];
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            check({tag, "_done_one_shot"}, done == 1'b0 && busy == 1'b0,
                  int'({done, busy}), 0);
        end
    endtask

    task automatic abort_at(input int n_req, input int t_abort,
                            input string tag);
        bit bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n_slots = n_req[9:0];
        @(negedge clk);
        start = 1'b0;
        repeat (t_abort - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_after_rst_tdbd"},
              {tx, de, busy, done} == 4'b1000,
              int'({tx, de, busy, done}), 8);
        repeat (20) begin
            @(negedge clk);
            if (done || busy || !tx || rd_en) bad = 1'b1;
        end
        check({tag, "_quiet_after_rst"}, !bad, int'(bad), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00;
        mem[1] = 8'h55;
        mem[2] = 8'hA3;
        mem[3] = 8'hFF;
        rst = 1'b1;
        start = 1'b0;
        n_slots = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx == 1'b1, int'(tx), 1);
        check("reset_de_busy_done", {de, busy, done} == 3'b000,
              int'({de, busy, done}), 0);
        check("reset_rd", rd_en == 1'b0 && rd_addr == 10'd0,
              int'({rd_en, rd_addr}), 0);

        vecs[0] = '{1, 1};
        vecs[1] = '{4, 4};
        vecs[2] = '{0, 1};
        vecs[3] = '{2, 2};
        vecs[4] = '{513, 513};
        vecs[5] = '{600, 513};
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].n_req, vecs[i].exp_cnt, 1'b0, 0, 0,
                      $sformatf("vec%0d", i));

        run_frame(5, 5, 1'b0, BRK + MAB + 11 * BIT + 3, 0, "ignore");
        run_frame(3, 3, 1'b0, 0, 2, "chainA");
        run_frame(2, 2, 1'b1, 0, 0, "chainB");

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 30));
            for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
            run_frame(n, n, 1'b0, 0, 0, $sformatf("rand%0d", r));
        end

        abort_at(5, 50, "rst_break");
        run_frame(10, 10, 1'b0, 0, 0, "post_rst1");
        abort_at(5, BRK + MAB + 2 * 11 * BIT + 5, "rst_slot2");
        run_frame(513, 513, 1'b0, 0, 0, "post_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
